// File: rtl/sram_like_arbiter.sv
// Arbitrates the core's inst and data sram-like ports onto one master port, one transaction at a time.
// Define ARB_RR_EN for round-robin arbitration; otherwise data has priority with a starvation limit.
module sram_like_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok
);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;  // 0 = inst, 1 = data
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        grant_inst, grant_data;

`ifdef ARB_RR_EN
  logic last_q, last_d;  // 1 = data was granted last
`else
  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);
  logic [3:0] starve_q, starve_d;
`endif

  // Grants only happen in IDLE and never while reset is asserted.
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (resetn && state_q == StIdle) begin
`ifdef ARB_RR_EN
      if (inst_req && data_req) begin
        grant_inst = last_q;
        grant_data = ~last_q;
        grant_inst = ~grant_data;
      end else begin
        grant_inst = inst_req;
        grant_data = data_req;
      end
`else
      if (data_req && !(inst_req && starve_q == StarveMax)) begin
        grant_data = 1'b1;
      end else begin
        grant_inst = inst_req;
      end
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    wr_d     = wr_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
`ifdef ARB_RR_EN
    last_d   = last_q;
`else
    starve_d = starve_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (grant_data) begin
          state_d = StAddr;
          owner_d = 1'b1;
          wr_d    = data_wr;
          size_d  = data_size;
          addr_d  = data_addr;
          wdata_d = data_wdata;
        end else if (grant_inst) begin
          state_d = StAddr;
          owner_d = 1'b0;
          wr_d    = inst_wr;
          size_d  = inst_size;
          addr_d  = inst_addr;
          wdata_d = inst_wdata;
        end
`ifdef ARB_RR_EN
        if (grant_data || grant_inst) begin
          last_d = grant_data;
        end
`else
        if (!inst_req || grant_inst) begin
          starve_d = 4'd0;
        end else if (grant_data && starve_q != StarveMax) begin
          starve_d = starve_q + 4'd1;
        end
`endif
      end
      StAddr: begin
        if (mem_addr_ok) begin
          state_d = StData;
        end
      end
      StData: begin
        if (mem_data_ok) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      wr_q     <= 1'b0;
      size_q   <= 2'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
`ifdef ARB_RR_EN
      last_q   <= 1'b1;
`else
      starve_q <= 4'd0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      wr_q     <= wr_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
`ifdef ARB_RR_EN
      last_q   <= last_d;
`else
      starve_q <= starve_d;
`endif
    end
  end

  logic done;
  assign done = resetn && state_q == StData && mem_data_ok;

  always_comb begin
    inst_addr_ok = grant_inst;
    data_addr_ok = grant_data;
    inst_data_ok = done && !owner_q;
    data_data_ok = done && owner_q;
    inst_rdata   = mem_rdata;
    data_rdata   = mem_rdata;
    mem_req      = resetn && state_q == StAddr;
    mem_wr       = wr_q;
    mem_size     = size_q;
    mem_addr     = addr_q;
    mem_wdata    = wdata_q;
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed self-checking bench for sram_like_arbiter (default build: fixed data priority).
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int failures = 0;

  sram_like_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; outputs are sampled 3 units later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    #3;
  endtask

  task automatic test_reset();
    resetn = 1'b0; inst_req = 1'b1; data_req = 1'b1;
    cyc(); cyc(); smp();
    checks++; if (inst_addr_ok !== 1'b0) begin failures++; $display("FAIL rst_inst_addr_ok got=%b exp=0", inst_addr_ok); end
    checks++; if (data_addr_ok !== 1'b0) begin failures++; $display("FAIL rst_data_addr_ok got=%b exp=0", data_addr_ok); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
    checks++; if ({mem_wr, mem_size} !== 3'b000) begin failures++; $display("FAIL rst_mem_wr_size got=%b exp=000", {mem_wr, mem_size}); end
    checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
    inst_req = 1'b0; data_req = 1'b0;
    cyc();
    resetn = 1'b1;
    cyc();
  endtask

  task automatic test_single_read();
    inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'hBFC0_0000;
    smp();
    checks++; if (inst_addr_ok !== 1'b1) begin failures++; $display("FAIL rd_inst_addr_ok got=%b exp=1", inst_addr_ok); end
    checks++; if (data_addr_ok !== 1'b0) begin failures++; $display("FAIL rd_data_addr_ok got=%b exp=0", data_addr_ok); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rd_mem_req_t0 got=%b exp=0", mem_req); end
    cyc();
    inst_req = 1'b0; mem_addr_ok = 1'b1;
    smp();
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rd_mem_req_t1 got=%b exp=1", mem_req); end
    checks++; if (mem_addr !== 32'hBFC0_0000) begin failures++; $display("FAIL rd_mem_addr got=%h exp=bfc00000", mem_addr); end
    checks++; if (mem_wr !== 1'b0) begin failures++; $display("FAIL rd_mem_wr got=%b exp=0", mem_wr); end
    cyc();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h3C08_BFAF;
    smp();
    checks++; if (inst_data_ok !== 1'b1) begin failures++; $display("FAIL rd_inst_data_ok got=%b exp=1", inst_data_ok); end
    checks++; if (inst_rdata !== 32'h3C08_BFAF) begin failures++; $display("FAIL rd_inst_rdata got=%h exp=3c08bfaf", inst_rdata); end
    checks++; if (data_data_ok !== 1'b0) begin failures++; $display("FAIL rd_data_data_ok got=%b exp=0", data_data_ok); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rd_mem_req_t2 got=%b exp=0", mem_req); end
    cyc();
    mem_data_ok = 1'b0;
    smp();
    checks++; if ({inst_data_ok, data_data_ok, mem_req} !== 3'b000) begin failures++; $display("FAIL rd_idle_after got=%b exp=000", {inst_data_ok, data_data_ok, mem_req}); end
    cyc();
  endtask

  task automatic test_simultaneous();
    inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'hBFC0_0004;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h8000_0010;
    data_wdata = 32'h1234_5678;
    smp();
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin failures++; $display("FAIL sim_first_grant got=%b exp=01", {inst_addr_ok, data_addr_ok}); end
    cyc();
    data_req = 1'b0; mem_addr_ok = 1'b1;
    smp();
    checks++; if (mem_req !== 1'b1 || mem_wr !== 1'b1) begin failures++; $display("FAIL sim_mem_req_wr got=%b%b exp=11", mem_req, mem_wr); end
    checks++; if (mem_wdata !== 32'h1234_5678) begin failures++; $display("FAIL sim_mem_wdata got=%h exp=12345678", mem_wdata); end
    checks++; if (mem_addr !== 32'h8000_0010 || mem_size !== 2'd2) begin failures++; $display("FAIL sim_mem_addr got=%h/%0d exp=80000010/2", mem_addr, mem_size); end
    checks++; if (inst_addr_ok !== 1'b0) begin failures++; $display("FAIL sim_inst_wait got=%b exp=0", inst_addr_ok); end
    cyc();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    smp();
    checks++; if ({inst_data_ok, data_data_ok, inst_addr_ok} !== 3'b010) begin failures++; $display("FAIL sim_data_done got=%b exp=010", {inst_data_ok, data_data_ok, inst_addr_ok}); end
    cyc();
    mem_data_ok = 1'b0;
    smp();
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin failures++; $display("FAIL sim_second_grant got=%b exp=10", {inst_addr_ok, data_addr_ok}); end
    cyc();
    inst_req = 1'b0; mem_addr_ok = 1'b1;
    smp();
    checks++; if (mem_addr !== 32'hBFC0_0004 || mem_wr !== 1'b0) begin failures++; $display("FAIL sim_inst_fields got=%h/%b exp=bfc00004/0", mem_addr, mem_wr); end
    cyc();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    smp();
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin failures++; $display("FAIL sim_inst_done got=%b exp=10", {inst_data_ok, data_data_ok}); end
    cyc();
    mem_data_ok = 1'b0;
    cyc();
  endtask

  task automatic test_starvation();
    logic [9:0] exp_inst;
    logic g_inst, g_data;
    exp_inst = 10'b10_0001_0000;  // bit i set: grant i goes to inst
    inst_req = 1'b1; data_req = 1'b1; inst_wr = 1'b0; data_wr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      smp();
      g_inst = inst_addr_ok; g_data = data_addr_ok;
      checks++; if ({g_inst, g_data} !== {exp_inst[i], ~exp_inst[i]}) begin failures++; $display("FAIL starve_grant_%0d got=%b exp=%b", i, {g_inst, g_data}, {exp_inst[i], ~exp_inst[i]}); end
      cyc();
      mem_addr_ok = 1'b1;
      cyc();
      mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
      smp();
      checks++; if ({inst_data_ok, data_data_ok} !== {exp_inst[i], ~exp_inst[i]}) begin failures++; $display("FAIL starve_done_%0d got=%b exp=%b", i, {inst_data_ok, data_data_ok}, {exp_inst[i], ~exp_inst[i]}); end
      cyc();
      mem_data_ok = 1'b0;
    end
    inst_req = 1'b0; data_req = 1'b0;
    cyc();
  endtask

  task automatic test_addr_stall();
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'h8000_0020;
    smp();
    checks++; if (data_addr_ok !== 1'b1) begin failures++; $display("FAIL stall_grant got=%b exp=1", data_addr_ok); end
    cyc();
    data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'hBFC0_0100;
    for (int s = 0; s < 5; s++) begin
      mem_data_ok = (s == 2);
      smp();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8000_0020 || mem_size !== 2'd0) begin failures++; $display("FAIL stall_hold_%0d got=%b/%h/%0d exp=1/80000020/0", s, mem_req, mem_addr, mem_size); end
      checks++; if ({inst_addr_ok, data_addr_ok, data_data_ok} !== 3'b000) begin failures++; $display("FAIL stall_quiet_%0d got=%b exp=000", s, {inst_addr_ok, data_addr_ok, data_data_ok}); end
      cyc();
    end
    mem_data_ok = 1'b0; mem_addr_ok = 1'b1;
    smp();
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL stall_release got=%b exp=1", mem_req); end
    cyc();
    mem_addr_ok = 1'b0; inst_req = 1'b0;
    smp();
    checks++; if ({mem_req, data_data_ok, inst_addr_ok} !== 3'b000) begin failures++; $display("FAIL stall_data_wait got=%b exp=000", {mem_req, data_data_ok, inst_addr_ok}); end
    cyc();
    mem_data_ok = 1'b1;
    smp();
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin failures++; $display("FAIL stall_done got=%b exp=01", {inst_data_ok, data_data_ok}); end
    cyc();
    mem_data_ok = 1'b0;
    cyc();
  endtask

  task automatic test_reset_in_data();
    inst_req = 1'b1; inst_wr = 1'b1; inst_addr = 32'hBFC0_0200; inst_wdata = 32'hA5A5_A5A5;
    smp();
    checks++; if (inst_addr_ok !== 1'b1) begin failures++; $display("FAIL rid_grant got=%b exp=1", inst_addr_ok); end
    cyc();
    inst_req = 1'b0; mem_addr_ok = 1'b1;
    cyc();
    mem_addr_ok = 1'b0; resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    smp();
    checks++; if ({mem_req, mem_wr, inst_addr_ok, data_addr_ok} !== 4'b0000) begin failures++; $display("FAIL rid_outputs got=%b exp=0000", {mem_req, mem_wr, inst_addr_ok, data_addr_ok}); end
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin failures++; $display("FAIL rid_fields got=%h/%h exp=0/0", mem_addr, mem_wdata); end
    cyc();
    mem_data_ok = 1'b1; mem_addr_ok = 1'b1;
    smp();
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin failures++; $display("FAIL rid_dropped got=%b exp=00", {inst_data_ok, data_data_ok}); end
    cyc();
    mem_data_ok = 1'b0; mem_addr_ok = 1'b0;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_1000;
    smp();
    checks++; if ({mem_req, data_addr_ok} !== 2'b01) begin failures++; $display("FAIL rid_next_grant got=%b exp=01", {mem_req, data_addr_ok}); end
    cyc();
    data_req = 1'b0; mem_addr_ok = 1'b1;
    smp();
    checks++; if (mem_addr !== 32'h0000_1000) begin failures++; $display("FAIL rid_next_addr got=%h exp=00001000", mem_addr); end
    cyc();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hCAFE_F00D;
    smp();
    checks++; if (data_data_ok !== 1'b1 || data_rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL rid_next_done got=%b/%h exp=1/cafef00d", data_data_ok, data_rdata); end
    cyc();
    mem_data_ok = 1'b0;
    cyc();
  endtask

  initial begin
    resetn = 1'b0;
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd0; inst_addr = 32'h0; inst_wdata = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'h0; data_wdata = 32'h0;
    mem_rdata = 32'h0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    cyc();
    test_reset();
    test_single_read();
    test_simultaneous();
    test_starvation();
    test_addr_stall();
    test_reset_in_data();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
